// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, register-zero ID, ALU opcode
// encodings and the ID/EX bundle layout with its bubble (NOP) value.
package pipeline_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;
  localparam int OP_W_DEF   = 4;

  // R0 is hard-wired to zero, so it never carries a real dependency
  localparam logic [REG_W_DEF-1:0] R0 = '0;

  typedef enum logic [OP_W_DEF-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLT = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7
  } alu_op_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_W_DEF-1:0]  rs;
    logic [REG_W_DEF-1:0]  rt;
    logic [REG_W_DEF-1:0]  rd;
    logic [DATA_W_DEF-1:0] rsData;
    logic [DATA_W_DEF-1:0] rtData;
    logic [DATA_W_DEF-1:0] imm;
    logic [OP_W_DEF-1:0]   aluOp;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  alusrc;
    logic                  memtoreg;
  } id_ex_bundle_t;

  // A bubble is all-zero: invalid, no register write, no memory access
  localparam id_ex_bundle_t ID_EX_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-Execute bus: the decoded bundle going in, the registered bundle,
// the load-use stall and the bubble counter coming back.
// master = Decode/control side, slave = the ID/EX stage.
interface id_ex_stage_if
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int OP_W   = OP_W_DEF
);

  logic              hold;
  logic              flush;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [OP_W-1:0]   id_alu_op;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_alusrc;
  logic              id_memtoreg;

  logic              stall;
  logic              ex_valid;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [OP_W-1:0]   ex_alu_op;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_alusrc;
  logic              ex_memtoreg;
  logic [15:0]       stall_count;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_alu_op, id_regwrite, id_memread,
           id_memwrite, id_alusrc, id_memtoreg,
    input  stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
           ex_alu_op, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc,
           ex_memtoreg, stall_count
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_alu_op, id_regwrite, id_memread,
           id_memwrite, id_alusrc, id_memtoreg,
    output stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
           ex_alu_op, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc,
           ex_memtoreg, stall_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector. Raises stall when a valid load in
// Execute writes a register that a live Decode instruction actually reads.
// R0 never creates a hazard; a flushed Decode instruction never stalls.
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             exValid_i,
  input  logic             exMemread_i,
  input  logic [REG_W-1:0] exRd_i,
  input  logic             idValid_i,
  input  logic             idUsesRs_i,
  input  logic [REG_W-1:0] idRs_i,
  input  logic             idUsesRt_i,
  input  logic [REG_W-1:0] idRt_i,
  input  logic             flush_i,
  output logic             stall_o
);

  logic rsMatch;
  logic rtMatch;

  // Compare each used source against the load destination and qualify it
  always_comb begin
    rsMatch = idUsesRs_i && (idRs_i == exRd_i);
    rtMatch = idUsesRt_i && (idRt_i == exRd_i);
    stall_o = exValid_i && exMemread_i && (|exRd_i) && (rsMatch || rtMatch)
              && idValid_i && !flush_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Edge priority: hold (freeze) > flush (bubble) > stall (bubble, counted)
// > capture. An invalid Decode slot is stored as a bubble.
// Optional feature macro: ID_EX_STALL_CNT_EN builds a saturating 16-bit
// counter of load-use bubbles; otherwise stall_count is tied to 0.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  id_ex_bundle_t     bundle_q;
  id_ex_bundle_t     bundle_d;
  logic              stall;
  logic [REG_W-1:0]  idRs;
  logic [REG_W-1:0]  idRt;
  logic [REG_W-1:0]  idRd;
  logic [DATA_W-1:0] idRsData;
  logic [DATA_W-1:0] idRtData;
  logic [DATA_W-1:0] idImm;
  logic [OP_W-1:0]   idAluOp;

  assign idRs     = bus.id_rs;
  assign idRt     = bus.id_rt;
  assign idRd     = bus.id_rd;
  assign idRsData = bus.id_rs_data;
  assign idRtData = bus.id_rt_data;
  assign idImm    = bus.id_imm;
  assign idAluOp  = bus.id_alu_op;

  load_use_detect #(.REG_W(REG_W)) u_detect (
    .exValid_i   (bundle_q.valid),
    .exMemread_i (bundle_q.memread),
    .exRd_i      (bundle_q.rd),
    .idValid_i   (bus.id_valid),
    .idUsesRs_i  (bus.id_uses_rs),
    .idRs_i      (idRs),
    .idUsesRt_i  (bus.id_uses_rt),
    .idRt_i      (idRt),
    .flush_i     (bus.flush),
    .stall_o     (stall)
  );

  // Next bundle: freeze, bubble, or the decoded instruction
  always_comb begin
    bundle_d = bundle_q;
    if (bus.hold) begin
      bundle_d = bundle_q;
    end else if (bus.flush || stall || !bus.id_valid) begin
      bundle_d = ID_EX_NOP;
    end else begin
      bundle_d.valid    = 1'b1;
      bundle_d.rs       = idRs;
      bundle_d.rt       = idRt;
      bundle_d.rd       = idRd;
      bundle_d.rsData   = idRsData;
      bundle_d.rtData   = idRtData;
      bundle_d.imm      = idImm;
      bundle_d.aluOp    = idAluOp;
      bundle_d.regwrite = bus.id_regwrite;
      bundle_d.memread  = bus.id_memread;
      bundle_d.memwrite = bus.id_memwrite;
      bundle_d.alusrc   = bus.id_alusrc;
      bundle_d.memtoreg = bus.id_memtoreg;
    end
  end

  // Bundle register, cleared asynchronously to a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bundle_q <= ID_EX_NOP;
    else     bundle_q <= bundle_d;
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stallCount_q;
  logic [15:0] stallCount_d;

  // Count load-use bubbles only; saturate instead of wrapping
  always_comb begin
    stallCount_d = stallCount_q;
    if (!bus.hold && stall && (stallCount_q != 16'hFFFF))
      stallCount_d = stallCount_q + 16'd1;
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stallCount_q <= '0;
    else     stallCount_q <= stallCount_d;
  end

  assign bus.stall_count = stallCount_q;
`else
  assign bus.stall_count = '0;
`endif

  assign bus.stall       = stall;
  assign bus.ex_valid    = bundle_q.valid;
  assign bus.ex_rs       = bundle_q.rs;
  assign bus.ex_rt       = bundle_q.rt;
  assign bus.ex_rd       = bundle_q.rd;
  assign bus.ex_rs_data  = bundle_q.rsData;
  assign bus.ex_rt_data  = bundle_q.rtData;
  assign bus.ex_imm      = bundle_q.imm;
  assign bus.ex_alu_op   = bundle_q.aluOp;
  assign bus.ex_regwrite = bundle_q.regwrite;
  assign bus.ex_memread  = bundle_q.memread;
  assign bus.ex_memwrite = bundle_q.memwrite;
  assign bus.ex_alusrc   = bundle_q.alusrc;
  assign bus.ex_memtoreg = bundle_q.memtoreg;

endmodule
